// File: rtl/dcache_arbiter_if.sv
// Request/ack and memory-port bundle for the data-cache arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dcache_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    logic          dc_ena;
    logic [AW-1:0] dc_addra;
    logic [DW-1:0] dc_douta;
    logic          dc_enb;
    logic          dc_web;
    logic [AW-1:0] dc_addrb;
    logic [DW-1:0] dc_dinb;

    logic [15:0]   conflict_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output dc_ena, dc_addra,
        input  dc_douta,
        output dc_enb, dc_web, dc_addrb, dc_dinb,
        output conflict_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  dc_ena, dc_addra,
        output dc_douta,
        input  dc_enb, dc_web, dc_addrb, dc_dinb,
        input  conflict_cnt
    );
endinterface

// File: rtl/dcache_arbiter.sv
// Two-requester arbiter for the data cache: CPU vs host, read port A
// (combinational) and write port B (clocked), with bounded host starvation.
module dcache_arbiter #(
    parameter int AW            = 9,
    parameter int DW            = 32,
    parameter int HOST_MAX_WAIT = 4
) (
    input logic clk,
    input logic rst_n,
    dcache_arbiter_if.slave bus
);
    localparam logic [3:0] MAXW = 4'(HOST_MAX_WAIT);

    logic          cpu_rd, cpu_wr;
    logic          host_rd, host_wr;
    logic          conflict;
    logic          host_pri;
    logic          cpu_gnt, host_gnt;
    logic          cpu_gnt_rd, cpu_gnt_wr;
    logic          host_gnt_rd, host_gnt_wr;

    logic          ena, enb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dinb;
    logic [DW-1:0] rd_data;

    logic          cpu_ack_q, host_ack_q;
    logic [DW-1:0] cpu_rdata_q, host_rdata_q;
    logic [3:0]    wcnt_q;
    logic [15:0]   cnt_q;

    // Nothing is granted while reset is held, so no write can land
    assign cpu_rd  = rst_n & bus.cpu_req & ~bus.cpu_we;
    assign cpu_wr  = rst_n & bus.cpu_req & bus.cpu_we;
    assign host_rd = rst_n & bus.host_req & ~bus.host_we;
    assign host_wr = rst_n & bus.host_req & bus.host_we;

    assign conflict = (cpu_rd & host_rd) | (cpu_wr & host_wr);
    assign host_pri = (wcnt_q == MAXW);

    assign cpu_gnt  = (cpu_rd | cpu_wr) & ~(conflict & host_pri);
    assign host_gnt = (host_rd | host_wr) & ~(conflict & ~host_pri);

    assign cpu_gnt_rd  = cpu_gnt & ~bus.cpu_we;
    assign cpu_gnt_wr  = cpu_gnt & bus.cpu_we;
    assign host_gnt_rd = host_gnt & ~bus.host_we;
    assign host_gnt_wr = host_gnt & bus.host_we;

    always_comb begin
        ena   = 1'b0;
        addra = '0;
        unique case (1'b1)
            cpu_gnt_rd: begin
                ena   = 1'b1;
                addra = bus.cpu_addr;
            end
            host_gnt_rd: begin
                ena   = 1'b1;
                addra = bus.host_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        enb   = 1'b0;
        addrb = '0;
        dinb  = '0;
        unique case (1'b1)
            cpu_gnt_wr: begin
                enb   = 1'b1;
                addrb = bus.cpu_addr;
                dinb  = bus.cpu_wdata;
            end
            host_gnt_wr: begin
                enb   = 1'b1;
                addrb = bus.host_addr;
                dinb  = bus.host_wdata;
            end
            default: ;
        endcase
    end

    // A read racing a same-address write sees the new data
    assign rd_data = (ena && enb && addra == addrb) ? dinb : bus.dc_douta;

    assign bus.dc_ena   = ena;
    assign bus.dc_addra = addra;
    assign bus.dc_enb   = enb;
    assign bus.dc_web   = enb;
    assign bus.dc_addrb = addrb;
    assign bus.dc_dinb  = dinb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            cpu_ack_q  <= cpu_gnt;
            host_ack_q <= host_gnt;
            if (cpu_gnt_rd)
                cpu_rdata_q <= rd_data;
            if (host_gnt_rd)
                host_rdata_q <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (!bus.host_req || host_gnt) begin
            wcnt_q <= '0;
        end else if (conflict && wcnt_q < MAXW) begin
            wcnt_q <= wcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (conflict && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.host_ack     = host_ack_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_dcache_arbiter.sv
// Scoreboard bench for dcache_arbiter with a behavioural data-cache memory.
// Directed vectors push expected ack data; a monitor pops on every ack.
module tb_dcache_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dcache_arbiter_if #(.AW(9), .DW(32)) bus ();

    dcache_arbiter #(.AW(9), .DW(32), .HOST_MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [512];

    assign bus.dc_douta = mem[bus.dc_addra];

    always @(posedge clk)
        if (bus.dc_enb && bus.dc_web)
            mem[bus.dc_addrb] <= bus.dc_dinb;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cq [$];
    logic [31:0] hq [$];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.cpu_ack) begin
            if (cq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cpu_ack: unexpected ack, rdata 0x%08h", bus.cpu_rdata);
            end else begin
                chk("cpu_rdata", bus.cpu_rdata, cq.pop_front());
            end
        end
        if (bus.host_ack) begin
            if (hq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL host_ack: unexpected ack, rdata 0x%08h", bus.host_rdata);
            end else begin
                chk("host_rdata", bus.host_rdata, hq.pop_front());
            end
        end
    end

    task automatic drive(input bit cr, input bit cw, input logic [8:0] ca,
                         input logic [31:0] cd, input bit hr, input bit hw,
                         input logic [8:0] ha, input logic [31:0] hd);
        bus.cpu_req    = cr;
        bus.cpu_we     = cw;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = cd;
        bus.host_req   = hr;
        bus.host_we    = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hd;
    endtask

    task automatic idle();
        drive(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++)
            mem[i] = 32'h0;
        mem[9'h001] = 32'h0000_00A1;
        mem[9'h002] = 32'h0000_00B2;
        mem[9'h020] = 32'h2020_2020;
        mem[9'h040] = 32'h1111_1111;
        mem[9'h050] = 32'h5555_5555;
        idle();

        // Reset state, request ignored while in reset
        @(negedge clk);
        drive(1, 1, 9'h010, 32'h1234_5678, 1, 0, 9'h002, 32'h0);
        #1;
        chk("rst dc_ena", 32'(bus.dc_ena), 32'h0);
        chk("rst dc_web", 32'(bus.dc_web), 32'h0);
        chk("rst acks", {30'h0, bus.cpu_ack, bus.host_ack}, 32'h0);
        chk("rst cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst host_rdata", bus.host_rdata, 32'h0);
        chk("rst conflict_cnt", 32'(bus.conflict_cnt), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst mem 010", mem[9'h010], 32'h0);

        // CPU write then read-back
        drive(1, 1, 9'h010, 32'hDEAD_BEEF, 0, 0, 9'h0, 32'h0);
        cq.push_back(32'h0);
        #1;
        chk("wr dc_web", 32'(bus.dc_web), 32'h1);
        chk("wr dc_addrb", 32'(bus.dc_addrb), 32'h010);
        chk("wr dc_dinb", bus.dc_dinb, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
        cq.push_back(32'hDEAD_BEEF);
        #1;
        chk("rd dc_ena", 32'(bus.dc_ena), 32'h1);
        chk("rd dc_enb", 32'(bus.dc_enb), 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Different ports: both granted, no conflict
        drive(1, 0, 9'h020, 32'h0, 1, 1, 9'h030, 32'h3030_3030);
        cq.push_back(32'h2020_2020);
        hq.push_back(32'h0);
        #1;
        chk("split ens", {30'h0, bus.dc_ena, bus.dc_enb}, 32'h3);
        chk("split addra", 32'(bus.dc_addra), 32'h020);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("split conflict_cnt", 32'(bus.conflict_cnt), 32'h0);
        chk("split mem 030", mem[9'h030], 32'h3030_3030);

        // Read conflict: host loses four times, wins the fifth
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
            if (i < 5) cq.push_back(32'h0000_00A1);
            else hq.push_back(32'h0000_00B2);
            #1;
            chk($sformatf("starve addra %0d", i), 32'(bus.dc_addra),
                (i < 5) ? 32'h001 : 32'h002);
            @(negedge clk);
        end
        chk("starve conflict_cnt", 32'(bus.conflict_cnt), 32'd5);
        drive(1, 0, 9'h001, 32'h0, 0, 0, 9'h0, 32'h0);
        cq.push_back(32'h0000_00A1);
        #1;
        chk("resume addra", 32'(bus.dc_addra), 32'h001);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Same-address read/write hazard: read sees new data
        drive(1, 1, 9'h040, 32'h2222_2222, 1, 0, 9'h040, 32'h0);
        cq.push_back(32'h0000_00A1);
        hq.push_back(32'h2222_2222);
        @(negedge clk);
        drive(0, 0, 9'h0, 32'h0, 1, 0, 9'h040, 32'h0);
        hq.push_back(32'h2222_2222);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Write conflict: CPU wins, host retries alone
        drive(1, 1, 9'h060, 32'h6, 1, 1, 9'h060, 32'h7);
        cq.push_back(32'h0000_00A1);
        #1;
        chk("wconf dc_dinb", bus.dc_dinb, 32'h6);
        @(negedge clk);
        drive(0, 0, 9'h0, 32'h0, 1, 1, 9'h060, 32'h7);
        hq.push_back(32'h2222_2222);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("wconf mem 060", mem[9'h060], 32'h7);
        chk("wconf conflict_cnt", 32'(bus.conflict_cnt), 32'd6);

        // Saturation of the conflict counter
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        chk("sat preload", 32'(bus.conflict_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
            cq.push_back(32'h0000_00A1);
            @(negedge clk);
            if (i == 1)
                chk("sat 2 conflicts", 32'(bus.conflict_cnt), 32'h0000_FFFF);
        end
        chk("sat 3 conflicts", 32'(bus.conflict_cnt), 32'h0000_FFFF);
        idle();
        @(negedge clk);

        // Reset asserted mid-cycle during a pending write
        drive(1, 0, 9'h001, 32'h0, 0, 0, 9'h0, 32'h0);
        cq.push_back(32'h0000_00A1);
        @(negedge clk);
        drive(1, 1, 9'h050, 32'h9999_9999, 0, 0, 9'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst cpu_ack", 32'(bus.cpu_ack), 32'h0);
        chk("mid-rst cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("mid-rst dc_enb", {30'h0, bus.dc_enb, bus.dc_web}, 32'h0);
        @(negedge clk);
        chk("mid-rst mem 050", mem[9'h050], 32'h5555_5555);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 0, 9'h050, 32'h0, 0, 0, 9'h0, 32'h0);
        cq.push_back(32'h5555_5555);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);

        chk("cpu queue drained", 32'(cq.size()), 32'h0);
        chk("host queue drained", 32'(hq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Shares the single data-cache memory between two requesters: the CPU memory stage and the host software-register access path.
- The memory has a combinational-read port A and a port B that writes on the clock edge.
- The block decides each cycle which requester owns the read port and which owns the write port, and drives both memory ports.
- It returns read data and a one-cycle ack, bounds host starvation, and counts conflicts for debug.

Parameters:
AW, 9, data cache word-address width
DW, 32, data width
HOST_MAX_WAIT, 4, consecutive lost conflicts after which the host wins the next conflict (1..15)

Ports:
clk  input  1  system clock; also drives memory clka/clkb
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request, level, sampled at posedge
cpu_we  input  1  1=write, 0=read
cpu_addr  input  AW  CPU word address
cpu_wdata  input  DW  CPU write data
cpu_ack  output  1  one-cycle pulse: CPU access accepted at previous edge
cpu_rdata  output  DW  read data, valid while cpu_ack=1 for a read
host_req  input  1  host access request
host_we  input  1  1=write, 0=read
host_addr  input  AW  host word address
host_wdata  input  DW  host write data
host_ack  output  1  one-cycle pulse, same rules as cpu_ack
host_rdata  output  DW  host read data, valid with host_ack
dc_ena  output  1  memory port A enable
dc_addra  output  AW  memory port A address
dc_douta  input  DW  memory port A combinational read data
dc_enb  output  1  memory port B enable
dc_web  output  1  memory port B write enable
dc_addrb  output  AW  memory port B address
dc_dinb  output  DW  memory port B write data
conflict_cnt  output  16  saturating count of conflicted cycles

Behaviour:
- Reset (rst_n=0, async): cpu_ack=host_ack=0, cpu_rdata=host_rdata=0, wait counter=0, conflict_cnt=0. While rst_n=0, dc_ena=dc_enb=dc_web=0 and no grant is issued. The first arbitration is at the first posedge with rst_n=1.
- Each cycle, a requester with req=1 asks for the read port (we=0) or the write port (we=1).
- Port grant is combinational from the current req/we inputs. Memory outputs follow the grant in the same cycle:
  - Read grant: dc_ena=1, dc_addra=winner addr.
  - Write grant: dc_enb=dc_web=1, dc_addrb/dc_dinb from winner.
  - Ungranted port: enable=0, address/data driven to 0.
- No conflict (requests target different ports, or only one requester active): both requests are granted in the same cycle.
- Conflict (both requesters active, same port type):
  - CPU wins by default.
  - Host wins if wait counter == HOST_MAX_WAIT.
  - Loser is not acked; it must hold req/we/addr/wdata stable.
- Wait counter (4 bits):
  - +1 on each conflict the host loses.
  - Cleared when the host is granted, or when host_req=0.
  - Never exceeds HOST_MAX_WAIT.
- conflict_cnt: +1 on every conflict cycle; saturates at 0xFFFF.
- Accept at posedge E:
  - Write: memory updates at E.
  - Read: dc_douta is captured into x_rdata at E.
  - x_ack=1 for the cycle after E; x_rdata holds its value until the next accepted read by that requester.
- Requester protocol: keep req high until ack is seen. If req is still high in the ack cycle, that is a new request and is arbitrated at E+1. Sustained throughput: one access per cycle per requester when uncontested.
- Same-cycle read/write hazard: one requester reads address A while the other writes address A in the same cycle. The read returns the write data (bypass of dc_dinb), not the old memory value.
- Write acks carry no data; x_rdata is unchanged on a write ack.
- Reset asserted mid-access: acks and rdata clear immediately. Any write presented at the reset edge is not performed.

Test Plan:
- Reset, then CPU writes 0xDEADBEEF to addr 0x010, then reads 0x010 → dc_web=1, dc_addrb=0x010 in write cycle; cpu_ack next cycle; read ack returns cpu_rdata=0xDEADBEEF.
- CPU read 0x020 and host write 0x030 in the same cycle → both granted, both acks one cycle later, conflict_cnt stays 0.
- Both read continuously (CPU 0x001, host 0x002) with HOST_MAX_WAIT=4 → host loses 4 cycles, then is granted in cycle 5 with host_ack the next cycle; CPU acks resume; conflict_cnt=5 after 5 cycles.
- Host reads 0x040 (memory holds 0x11111111) while CPU writes 0x22222222 to 0x040 in the same cycle → host_rdata=0x22222222; a subsequent read of 0x040 also returns 0x22222222.
- Force conflict_cnt to 0xFFFE, then two conflict cycles → conflict_cnt stays at 0xFFFF.
- Assert rst_n=0 asynchronously mid-cycle while a CPU write to 0x050 is pending → acks go to 0 immediately, dc_enb=0, memory at 0x050 unchanged; after release, a CPU read of 0x050 returns the old value.
